mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle RISC-V control unit; successor to the single-cycle main decoder.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states and drives datapath mux selects and write strobes.
- Adds LUI, BNE, an optional memory ready-handshake and a sticky illegal-opcode trap.
- Sits between the instruction register (op/funct3) and the shared-memory multicycle datapath.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = memory states last one cycle and mem_ready is ignored.
- EN_LUI, 1, 1 = opcode 0110111 decoded; 0 = treated as illegal.
- EN_BNE, 1, 1 = branch funct3 001 decoded; 0 = treated as illegal.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  opcode from instruction register.
- funct3  in  3  funct3 from instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete.
- mem_req  out  1  memory access request.
- pc_write  out  1  PC register enable.
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR/OldPC enable.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- reg_write  out  1  register file write strobe.
- trap  out  1  illegal instruction, sticky.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Interface: one clock (clk); reset (reset_n) is asynchronous and active-low.
- Reset: state = FETCH (0).
  - While reset_n = 0, pc_write, ir_write, reg_write, mem_write and mem_req are forced 0.
  - trap clears to 0.
  - All other outputs take their FETCH values.
- Outputs: Moore-decoded from state, except pc_write and imm_src. Signals not listed for a state are 0.
- imm_src: combinational from op. lw/I-ALU 000, sw 001, branch 010, jal 011, lui 100, others 000.
- pc_write = pc_update | (branch & (zero ^ funct3[0])).
- States, outputs and transitions:
  - FETCH(0): mem_req=1, adr_src=0, ir_write, a=00, b=10, alu_op=00, result_src=10, pc_update. With MEM_HANDSHAKE=1, ir_write and pc_update are asserted only when mem_ready=1, and the state holds while mem_ready=0. Next: DECODE.
  - DECODE(1): a=01, b=01, alu_op=00. Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - 0110111 -> LUI
    - otherwise -> TRAP
  - MEMADR(2): a=10, b=01, alu_op=00. Next: MEMREAD for lw, MEMWR for sw.
  - MEMREAD(3): mem_req, adr_src=1, result_src=00. Holds while handshake enabled and mem_ready=0. Next: MEMWB.
  - MEMWB(4): result_src=01, reg_write. Next: FETCH.
  - MEMWR(5): mem_req, adr_src=1, result_src=00, mem_write. mem_write stays high until the mem_ready cycle. Next: FETCH.
  - EXECR(6): a=10, b=00, alu_op=10. Next: ALUWB.
  - ALUWB(7): result_src=00, reg_write. Next: FETCH.
  - EXECI(8): a=10, b=01, alu_op=10. Next: ALUWB.
  - JAL(9): a=01, b=10, alu_op=00, result_src=00, pc_update. Next: ALUWB.
  - BRANCH(10): a=10, b=00, alu_op=01, result_src=00, branch. Next: FETCH. funct3 other than 000, or other than 001 when EN_BNE=1, -> TRAP instead, with branch masked.
  - LUI(11): a=11, b=01, alu_op=00. Next: ALUWB.
  - TRAP(12): trap=1, all strobes 0. Stays until reset.
- Unused encodings 13-15 go to TRAP.
- Cycle counts with mem_ready tied 1:
  - lw 5; sw 4; R/I 4; jal 4; branch 3; lui 4.
  - Each mem_ready=0 cycle in a wait state adds one cycle.
- Reset asserted mid-instruction aborts it immediately: no partial write, FETCH on release.

Test Plan:
- add (op 0110011), mem_ready=1 -> states 0,1,6,7,0. reg_write high only in cycle 4. alu_op=10 in EXECR.
- lw with MEM_HANDSHAKE=1, mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0 (3 held 3 cycles). reg_write with result_src=01 once.
- beq zero=1 -> pc_write=1 in BRANCH. bne (funct3 001) zero=1 -> pc_write=0. bne zero=0 -> pc_write=1.
- lui (0110111) -> imm_src=100; LUI state a=11, b=01; then ALUWB with reg_write. With EN_LUI=0 -> TRAP.
- op 1111111 -> TRAP after DECODE. trap=1 and all strobes 0 for 20 cycles. reset_n pulse -> FETCH, trap=0.
- sw with MEM_HANDSHAKE=1, reset_n dropped while in MEMWR with mem_ready=0 -> mem_write falls to 0 asynchronously, state_o=0, no further mem_write after release until the next sw.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle RISC-V control FSM with memory handshake and sticky trap
module mc_ctrl_fsm #(
    parameter logic MEM_HANDSHAKE = 1'b1,
    parameter logic EN_LUI        = 1'b1,
    parameter logic EN_BNE        = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       trap,
    output logic [3:0] state_o
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_EXECI   = 4'd8;
    localparam logic [3:0] S_JAL     = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_LUI     = 4'd11;
    localparam logic [3:0] S_TRAP    = 4'd12;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_mem_ok;
    logic       w_branch_ok;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_reg_write;

    // Without the handshake every memory state completes in a single cycle.
    assign w_mem_ok    = !MEM_HANDSHAKE || mem_ready;
    assign w_branch_ok = (funct3 == 3'b000) || (EN_BNE && (funct3 == 3'b001));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:   w_next = w_mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECR;
                    OP_ITYPE:     w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BRANCH:    w_next = S_BRANCH;
                    OP_LUI:       w_next = EN_LUI ? S_LUI : S_TRAP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
            S_MEMREAD: w_next = w_mem_ok ? S_MEMWB : S_MEMREAD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = w_mem_ok ? S_FETCH : S_MEMWR;
            S_EXECR:   w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_EXECI:   w_next = S_ALUWB;
            S_JAL:     w_next = S_ALUWB;
            S_BRANCH:  w_next = w_branch_ok ? S_FETCH : S_TRAP;
            S_LUI:     w_next = S_ALUWB;
            default:   w_next = S_TRAP;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_ir_write  = w_mem_ok;
                w_pc_update = w_mem_ok;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                adr_src   = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req   = 1'b1;
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_ALUWB:   w_reg_write = 1'b1;
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                w_branch  = w_branch_ok;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:     imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

    // Strobes are gated by reset_n directly so an asserted reset kills them without waiting for a clock.
    assign pc_write  = reset_n & (w_pc_update | (w_branch & (zero ^ funct3[0])));
    assign ir_write  = reset_n & w_ir_write;
    assign mem_req   = reset_n & w_mem_req;
    assign mem_write = reset_n & w_mem_write;
    assign reg_write = reset_n & w_reg_write;
    assign trap      = (r_state == S_TRAP);
    assign state_o   = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed-vector bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       reset_n, reset_n2;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, mem_ready;

    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, trap;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [3:0] state_o;

    logic       mem_req2, pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, trap2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2, alu_op2;
    logic [2:0] imm_src2;
    logic [3:0] state_o2;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl_fsm dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .reg_write(reg_write), .trap(trap), .state_o(state_o)
    );

    mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .EN_LUI(1'b0), .EN_BNE(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n2), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req2), .pc_write(pc_write2), .adr_src(adr_src2),
        .mem_write(mem_write2), .ir_write(ir_write2), .result_src(result_src2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2), .imm_src(imm_src2),
        .reg_write(reg_write2), .trap(trap2), .state_o(state_o2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step_state(input string tag, input logic [3:0] exp);
        tick();
        check(tag, {28'd0, state_o}, {28'd0, exp});
    endtask

    initial begin
        reset_n = 1'b0; reset_n2 = 1'b0;
        op = OP_ADD; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        #3;
        check("rst_state",   {28'd0, state_o}, 32'd0);
        check("rst_strobes", {27'd0, pc_write, ir_write, reg_write, mem_write, mem_req}, 32'd0);
        check("rst_trap",    {31'd0, trap}, 32'd0);
        check("rst_mux",     {24'd0, alu_src_a, alu_src_b, alu_op, result_src}, 32'b00_10_00_10);

        // add: 0,1,6,7,0
        tick();
        reset_n = 1'b1;
        #1;
        check("add_fetch_strb", {28'd0, pc_write, ir_write, mem_req, adr_src}, 32'b1110);
        step_state("add_s1", 4'd1);
        check("add_dec_mux", {28'd0, alu_src_a, alu_src_b}, 32'b0101);
        step_state("add_s6", 4'd6);
        check("add_execr", {29'd0, alu_op, reg_write}, 32'b100);
        step_state("add_s7", 4'd7);
        check("add_aluwb", {29'd0, reg_write, result_src}, 32'b100);
        step_state("add_s0", 4'd0);

        // lw with two wait cycles in MEMREAD
        op = OP_LW;
        step_state("lw_s1", 4'd1);
        step_state("lw_s2", 4'd2);
        check("lw_memadr_mux", {28'd0, alu_src_a, alu_src_b}, 32'b1001);
        step_state("lw_s3", 4'd3);
        mem_ready = 1'b0;
        #1;
        check("lw_memread", {28'd0, mem_req, adr_src, result_src}, 32'b1100);
        step_state("lw_s3_w1", 4'd3);
        step_state("lw_s3_w2", 4'd3);
        mem_ready = 1'b1;
        step_state("lw_s4", 4'd4);
        check("lw_memwb", {29'd0, reg_write, result_src}, 32'b101);
        step_state("lw_s0", 4'd0);
        check("lw_done_rw", {31'd0, reg_write}, 32'd0);

        // sw, no wait
        op = OP_SW;
        #1;
        check("sw_imm", {29'd0, imm_src}, 32'b001);
        step_state("sw_s1", 4'd1);
        step_state("sw_s2", 4'd2);
        step_state("sw_s5", 4'd5);
        check("sw_memwr", {29'd0, mem_write, mem_req, adr_src}, 32'b111);
        step_state("sw_s0", 4'd0);
        check("sw_done_mw", {31'd0, mem_write}, 32'd0);

        // beq taken / not taken
        op = OP_BR; funct3 = 3'b000; zero = 1'b1;
        step_state("beq_s1", 4'd1);
        step_state("beq_s10", 4'd10);
        check("beq_z1_pcw", {31'd0, pc_write}, 32'd1);
        check("beq_mux", {25'd0, alu_src_a, alu_op, imm_src}, 32'b10_01_010);
        zero = 1'b0;
        #1;
        check("beq_z0_pcw", {31'd0, pc_write}, 32'd0);
        step_state("beq_s0", 4'd0);

        // bne
        funct3 = 3'b001; zero = 1'b1;
        step_state("bne_s1", 4'd1);
        step_state("bne_s10", 4'd10);
        check("bne_z1_pcw", {31'd0, pc_write}, 32'd0);
        zero = 1'b0;
        #1;
        check("bne_z0_pcw", {31'd0, pc_write}, 32'd1);
        step_state("bne_s0", 4'd0);

        // jal
        op = OP_JAL; funct3 = 3'b000;
        step_state("jal_s1", 4'd1);
        step_state("jal_s9", 4'd9);
        check("jal_pcw", {31'd0, pc_write}, 32'd1);
        check("jal_mux", {24'd0, alu_src_a, alu_src_b, alu_op, result_src}, 32'b01_10_00_00);
        step_state("jal_s7", 4'd7);
        step_state("jal_s0", 4'd0);

        // lui on both instances; dut2 has no handshake and no LUI
        op = OP_LUI;
        reset_n2 = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("lui_imm", {29'd0, imm_src}, 32'b100);
        check("fetch_wait_strb", {30'd0, ir_write, pc_write}, 32'd0);
        check("nohs_fetch_irw", {31'd0, ir_write2}, 32'd1);
        tick();
        check("fetch_wait_state", {28'd0, state_o}, 32'd0);
        check("nohs_s1", {28'd0, state_o2}, 32'd1);
        mem_ready = 1'b1;
        step_state("lui_s1", 4'd1);
        check("nolui_trap_state", {28'd0, state_o2}, 32'd12);
        check("nolui_trap", {31'd0, trap2}, 32'd1);
        step_state("lui_s11", 4'd11);
        check("lui_mux", {28'd0, alu_src_a, alu_src_b}, 32'b1101);
        step_state("lui_s7", 4'd7);
        check("lui_rw", {31'd0, reg_write}, 32'd1);
        step_state("lui_s0", 4'd0);
        reset_n2 = 1'b0;

        // illegal branch funct3
        op = OP_BR; funct3 = 3'b010; zero = 1'b1;
        step_state("bbad_s1", 4'd1);
        step_state("bbad_s10", 4'd10);
        check("bbad_pcw", {31'd0, pc_write}, 32'd0);
        step_state("bbad_s12", 4'd12);
        check("bbad_trap", {31'd0, trap}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("bbad_rst", {27'd0, state_o, trap}, 32'd0);
        reset_n = 1'b1;

        // illegal opcode: sticky trap for 20 cycles
        op = 7'b1111111; funct3 = 3'b000; zero = 1'b0;
        step_state("ill_s1", 4'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("ill_trap_%0d", i),
                  {22'd0, state_o, trap, pc_write, ir_write, reg_write, mem_write, mem_req},
                  {22'd0, 4'd12, 1'b1, 5'b0});
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("ill_rst", {27'd0, state_o, trap}, 32'd0);
        reset_n = 1'b1;

        // sw aborted by reset while waiting in MEMWR
        op = OP_SW;
        step_state("swr_s1", 4'd1);
        step_state("swr_s2", 4'd2);
        mem_ready = 1'b0;
        step_state("swr_s5", 4'd5);
        check("swr_mw_a", {31'd0, mem_write}, 32'd1);
        step_state("swr_s5_hold", 4'd5);
        check("swr_mw_b", {31'd0, mem_write}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("swr_abort_mw", {31'd0, mem_write}, 32'd0);
        check("swr_abort_st", {28'd0, state_o}, 32'd0);
        reset_n = 1'b1;
        op = OP_ADD; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("swr_post_mw_%0d", i), {31'd0, mem_write}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no summary expected finish");
        $fatal(1, "timeout");
    end

endmodule
